// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state enum and negate helpers for the HI/LO sequencer
package muldiv_pkg;

  localparam int ITER_COUNT = 32;

  // op[1] selects divide, op[0] selects unsigned
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_addsub33.sv
// rtl/muldiv_addsub33.sv - 33-bit add/subtract stage shared by every ITER cycle
// o_cout is the carry for an add and the borrow for a subtract.
module muldiv_addsub33 (
  input  logic [32:0] i_a,
  input  logic [32:0] i_b,
  input  logic        i_sub,
  output logic [32:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_b_eff;
  logic        w_carry;

  assign w_b_eff            = i_b ^ {33{i_sub}};
  assign {w_carry, o_sum}   = {1'b0, i_a} + {1'b0, w_b_eff} + {33'd0, i_sub};
  assign o_cout             = i_sub ? ~w_carry : w_carry;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer producing HI/LO
// Shift-add multiply and restoring divide on magnitudes, signs fixed up in FIX.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [4:0] CNT_LAST = 5'(ITER_COUNT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_accept;

  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic [31:0] r_mcand;
  logic [31:0] r_acc;
  logic [31:0] r_lo_acc;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dbz;

  logic        w_is_div;
  logic        w_signed;
  logic [32:0] w_add_a;
  logic [32:0] w_add_b;
  logic [32:0] w_sum;
  logic        w_cout;
  logic [32:0] w_acc33;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_dbz;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // DONE also accepts start so a new operation can be sampled on the edge that leaves DONE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = PREP;
      PREP:    w_state_nxt = ITER;
      ITER:    if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? PREP : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept   = start && (r_state == IDLE || r_state == DONE);
    w_busy_nxt = (w_state_nxt == PREP) || (w_state_nxt == ITER) || (w_state_nxt == FIX);
    w_done_nxt = (w_state_nxt == DONE);
  end

  muldiv_addsub33 u_addsub (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_sub  (w_is_div),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Divide feeds the shifted remainder; multiply feeds the accumulator
  assign w_add_a = w_is_div ? {r_acc, r_lo_acc[31]} : {1'b0, r_acc};
  assign w_add_b = {1'b0, r_mcand};
  assign w_acc33 = r_lo_acc[0] ? w_sum : {1'b0, r_acc};

  assign w_prod   = r_neg_res ? neg64({r_acc, r_lo_acc}) : {r_acc, r_lo_acc};
  assign w_quo    = r_neg_res ? neg32(r_lo_acc) : r_lo_acc;
  assign w_rem    = r_neg_rem ? neg32(r_acc) : r_acc;
  assign w_dbz    = w_is_div && (r_b == 32'd0);
  assign w_fix_hi = !w_is_div ? w_prod[63:32] : (w_dbz ? r_a : w_rem);
  assign w_fix_lo = !w_is_div ? w_prod[31:0]  : (w_dbz ? DBZ_LO : w_quo);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 2'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_mcand   <= 32'd0;
      r_acc     <= 32'd0;
      r_lo_acc  <= 32'd0;
      r_cnt     <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_dbz     <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
      unique case (r_state)
        PREP: begin
          r_neg_res <= w_signed && (r_a[31] ^ r_b[31]);
          r_neg_rem <= w_signed && r_a[31];
          r_mcand   <= w_signed ? abs32(r_b) : r_b;
          r_lo_acc  <= w_signed ? abs32(r_a) : r_a;
          r_acc     <= 32'd0;
          r_cnt     <= 5'd0;
        end
        ITER: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_is_div) begin
            r_acc    <= w_cout ? {r_acc[30:0], r_lo_acc[31]} : w_sum[31:0];
            r_lo_acc <= {r_lo_acc[30:0], ~w_cout};
          end else begin
            r_acc    <= w_acc33[32:1];
            r_lo_acc <= {w_acc33[0], r_lo_acc[31:1]};
          end
        end
        FIX: begin
          r_hi  <= w_fix_hi;
          r_lo  <= w_fix_lo;
          r_dbz <= w_dbz;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_cmp;
  int n_mis;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // HI/LO semantics from plain 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint      sx, sy, q, r;
    logic [63:0] p;
    ed = 1'b0;
    if (!o[1]) begin
      if (!o[0]) p = 64'(longint'($signed(x)) * longint'($signed(y)));
      else       p = {32'd0, x} * {32'd0, y};
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 32'd0) begin
      eh = x;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
    end else if (!o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = x / y;
      eh = x % y;
    end
  endfunction

  // Entered and left at a negedge; poke1/poke2 pulse start while the operation runs
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int poke1, input int poke2);
    logic [31:0] eh, el;
    logic        ed;
    int          n, busy_n;
    bit          got_done;
    model(o, x, y, eh, el, ed);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    n = 0; busy_n = 0; got_done = 1'b0;
    while (n < 100 && !got_done) begin
      if (busy) busy_n++;
      if (done) got_done = 1'b1;
      else begin
        if (n == 20) begin
          chk({name, ".hold_hi"}, 64'(hi), 64'(prev_hi));
          chk({name, ".hold_lo"}, 64'(lo), 64'(prev_lo));
        end
        start = (n == poke1) || (n == poke2);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk({name, ".done_seen"}, 64'(got_done), 64'd1);
    chk({name, ".latency"},   64'(n),        64'd34);
    chk({name, ".busy_cyc"},  64'(busy_n),   64'd34);
    chk({name, ".hi"},        64'(hi),       64'(eh));
    chk({name, ".lo"},        64'(lo),       64'(el));
    chk({name, ".dbz"},       64'(div_by_zero), 64'(ed));
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int extra;
    n_cmp = 0; n_mis = 0;
    prev_hi = 32'd0; prev_lo = 32'd0;
    reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi",   64'(hi),   64'd0);
    chk("rst.lo",   64'(lo),   64'd0);
    chk("rst.dbz",  64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    chk("multu_max.hi_k", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max.lo_k", 64'(lo), 64'h0000_0001);
    do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1);
    chk("mult_neg.lo_k", 64'(lo), 64'hFFFF_FFF1);
    do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1);
    chk("div_neg.lo_k", 64'(lo), 64'hFFFF_FFFD);
    do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("div_ovf.lo_k", 64'(lo), 64'h8000_0000);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, -1, -1);
    chk("divu_zero.hi_k", 64'(hi), 64'h64);
    do_op("multu_23",  2'b01, 32'd2, 32'd3, -1, -1);
    chk("multu_23.dbz_k", 64'(div_by_zero), 64'd0);

    do_op("divu_poke", 2'b11, 32'd1000, 32'd7, 5, 20);
    chk("divu_poke.lo_k", 64'(lo), 64'd142);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("divu_poke.extra_done", 64'(extra), 64'd0);

    op = 2'b00; a = 32'd12345; b = 32'hFFFF_E57B; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.hi",   64'(hi),   64'd0);
    chk("midrst.lo",   64'(lo),   64'd0);
    reset = 1'b0;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("midrst.quiet", 64'(extra), 64'd0);
    prev_hi = 32'd0; prev_lo = 32'd0;
    do_op("after_rst", 2'b00, 32'd12345, 32'hFFFF_E57B, -1, -1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'h8000_0000;
        default: rb = 32'($urandom);
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
